// File: rtl/serial_phy_rx.sv
// serial_phy_rx: per-lane serial receiver on the bit clock.
// Hunts for the idle comma at every bit offset, locks after LOCK_COUNT
// consecutive aligned commas, then packs four non-comma bytes (MSB first)
// into a 32-bit word for the lane un-striping logic.
//
// Ports:
//   clk       bit clock, all state updates on the rising edge
//   reset     asynchronous, active-low; clears all state
//   data_in   serial lane bit, MSB of each byte first
//   data_out  last assembled word, first received byte in [31:24]
//   valid_out one-cycle pulse when data_out is updated
//   active    lane aligned and locked (sticky until reset)
//   word_err  one-cycle pulse when a comma truncates a partial word
module serial_phy_rx #(
  parameter logic [7:0]  COMMA      = 8'hBC,
  parameter int unsigned LOCK_COUNT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_in,
  output logic [31:0] data_out,
  output logic        valid_out,
  output logic        active,
  output logic        word_err
);

  localparam logic [3:0] LockCnt = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {StSearch, StCount, StActive} state_e;

  state_e      state_q, state_d;
  // Only the seven most recent bits are stored; the eighth is data_in itself.
  logic [6:0]  sr_q, sr_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  comma_cnt_q, comma_cnt_d;
  logic [1:0]  byte_idx_q, byte_idx_d;
  logic [23:0] acc_q, acc_d;
  logic [31:0] data_out_q, data_out_d;
  logic        valid_q, valid_d;
  logic        active_q, active_d;
  logic        word_err_q, word_err_d;

  logic [7:0]  nb;
  logic        is_comma;
  logic        boundary;
  logic [3:0]  comma_inc;

  assign nb        = {sr_q, data_in};
  assign is_comma  = (nb == COMMA);
  assign boundary  = (bit_cnt_q == 3'd7);
  assign comma_inc = comma_cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    sr_d        = nb[6:0];
    bit_cnt_d   = bit_cnt_q;
    comma_cnt_d = comma_cnt_q;
    byte_idx_d  = byte_idx_q;
    acc_d       = acc_q;
    data_out_d  = data_out_q;
    valid_d     = 1'b0;
    active_d    = active_q;
    word_err_d  = 1'b0;

    unique case (state_q)
      StSearch: begin
        // Unaligned hunt: every bit offset is a candidate.
        if (is_comma) begin
          bit_cnt_d   = 3'd0;
          comma_cnt_d = 4'd1;
          state_d     = StCount;
        end
      end

      StCount: begin
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            comma_cnt_d = comma_inc;
            if (comma_inc == LockCnt) begin
              state_d  = StActive;
              active_d = 1'b1;
            end
          end else begin
            // Bit counter has wrapped to 0; search restarts on the next bit.
            comma_cnt_d = 4'd0;
            state_d     = StSearch;
          end
        end
      end

      StActive: begin
        // Alignment is frozen here; only reset leaves this state.
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (boundary) begin
          if (is_comma) begin
            if (byte_idx_q != 2'd0) begin
              byte_idx_d = 2'd0;
              word_err_d = 1'b1;
            end
          end else if (byte_idx_q == 2'd3) begin
            data_out_d = {acc_q, nb};
            valid_d    = 1'b1;
            byte_idx_d = 2'd0;
          end else begin
            acc_d      = {acc_q[15:0], nb};
            byte_idx_d = byte_idx_q + 2'd1;
          end
        end
      end

      default: state_d = StSearch;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StSearch;
      sr_q        <= '0;
      bit_cnt_q   <= '0;
      comma_cnt_q <= '0;
      byte_idx_q  <= '0;
      acc_q       <= '0;
      data_out_q  <= '0;
      valid_q     <= 1'b0;
      active_q    <= 1'b0;
      word_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      bit_cnt_q   <= bit_cnt_d;
      comma_cnt_q <= comma_cnt_d;
      byte_idx_q  <= byte_idx_d;
      acc_q       <= acc_d;
      data_out_q  <= data_out_d;
      valid_q     <= valid_d;
      active_q    <= active_d;
      word_err_q  <= word_err_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_q;
  assign active    = active_q;
  assign word_err  = word_err_q;

endmodule

// File: tb/tb_serial_phy_rx.sv
// Scoreboard bench for serial_phy_rx: stimulus pushes expected words and
// word_err events; a monitor pops and compares whenever the DUT presents one.
module tb_serial_phy_rx;

  logic        clk;
  logic        reset;
  logic        data_in;
  logic [31:0] data_out;
  logic        valid_out;
  logic        active;
  logic        word_err;

  serial_phy_rx #(
    .COMMA      (8'hBC),
    .LOCK_COUNT (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .data_in   (data_in),
    .data_out  (data_out),
    .valid_out (valid_out),
    .active    (active),
    .word_err  (word_err)
  );

  typedef struct {
    bit          is_err;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_valid_cyc = 0;
  int   prev_valid_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    data_in = b;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_commas(input int n);
    for (int i = 0; i < n; i++) send_byte(8'hBC);
  endtask

  task automatic push_word(input logic [31:0] w);
    exp_t e;
    e.is_err = 1'b0;
    e.data   = w;
    exp_q.push_back(e);
  endtask

  task automatic push_err();
    exp_t e;
    e.is_err = 1'b1;
    e.data   = '0;
    exp_q.push_back(e);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    data_in = 1'b0;
    reset   = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
  endtask

  // Wait for the edge that samples the last driven bit, then settle.
  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every DUT output event must match the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (valid_out === 1'b1 || word_err === 1'b1) begin
        if (valid_out === 1'b1) begin
          prev_valid_cyc = last_valid_cyc;
          last_valid_cyc = cyc;
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got valid=%b err=%b data=%h, expected none (t=%0t)",
                   valid_out, word_err, data_out, $time);
        end else begin
          e = exp_q.pop_front();
          chk("event_kind_err", {31'b0, word_err}, {31'b0, e.is_err});
          chk("event_kind_valid", {31'b0, valid_out}, {31'b0, ~e.is_err});
          if (!e.is_err) chk("word_data", data_out, e.data);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset   = 1'b0;
    data_in = 1'b0;

    // Reset held: random bits must not disturb the cleared outputs.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("rst_data_out", data_out, 32'h0);
      chk("rst_valid", {31'b0, valid_out}, 32'h0);
      chk("rst_active", {31'b0, active}, 32'h0);
      chk("rst_word_err", {31'b0, word_err}, 32'h0);
      data_in = 1'($urandom);
    end
    @(negedge clk);
    data_in = 1'b0;
    reset   = 1'b1;

    // Aligned lock and word.
    send_commas(3);
    after_edge();
    chk("aligned_active_after_3", {31'b0, active}, 32'h0);
    send_commas(1);
    after_edge();
    chk("aligned_active_after_4", {31'b0, active}, 32'h1);
    push_word(32'hFFFF_FFFF);
    for (int i = 0; i < 3; i++) send_byte(8'hFF);
    after_edge();
    chk("aligned_no_early_valid", {31'b0, valid_out}, 32'h0);
    send_byte(8'hFF);
    after_edge();
    chk("aligned_valid_timing", {31'b0, valid_out}, 32'h1);
    send_commas(2);

    // Offset acquisition.
    reset_pulse();
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_commas(4);
    after_edge();
    chk("offset_active", {31'b0, active}, 32'h1);
    push_word(32'hEEEE_EEEE);
    push_word(32'hDDDD_DDDD);
    for (int i = 0; i < 4; i++) send_byte(8'hEE);
    for (int i = 0; i < 4; i++) send_byte(8'hDD);
    send_commas(1);
    chk("offset_valid_spacing", 32'(last_valid_cyc - prev_valid_cyc), 32'd32);

    // Failed lock, then relock.
    reset_pulse();
    send_commas(3);
    send_byte(8'h00);
    after_edge();
    chk("failed_lock_active", {31'b0, active}, 32'h0);
    send_commas(3);
    after_edge();
    chk("relock_not_yet", {31'b0, active}, 32'h0);
    send_commas(1);
    after_edge();
    chk("relock_active", {31'b0, active}, 32'h1);
    push_word(32'h0000_0003);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h00);
    send_byte(8'h03);
    send_commas(1);

    // Truncated word.
    push_err();
    send_byte(8'hAA);
    send_byte(8'h99);
    send_byte(8'hBC);
    after_edge();
    chk("trunc_err_pulse", {31'b0, word_err}, 32'h1);
    push_word(32'hAAAA_AAAA);
    for (int i = 0; i < 4; i++) send_byte(8'hAA);
    send_commas(1);

    // Reset mid-word: outputs clear without a clock edge.
    send_byte(8'h11);
    send_byte(8'h22);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("midrst_active", {31'b0, active}, 32'h0);
    chk("midrst_data_out", data_out, 32'h0);
    repeat (3) @(negedge clk);
    data_in = 1'b0;
    reset   = 1'b1;
    send_commas(4);
    after_edge();
    chk("midrst_relock", {31'b0, active}, 32'h1);
    push_word(32'hCCCC_CCCC);
    for (int i = 0; i < 4; i++) send_byte(8'hCC);
    send_commas(2);

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/serial_phy_rx.md
# serial_phy_rx

Per-lane serial receiver that sits directly downstream of the PHY transmitter lanes, one instance per lane (lane 0, lane 1).
- Runs on the bit clock (the clk_32f domain) and samples the serial lane MSB-first.
- Finds byte alignment by hunting for the idle comma, and declares the lane active after LOCK_COUNT consecutive aligned commas.
- Reassembles 4 non-comma bytes into a 32-bit word with a one-cycle valid strobe, for the lane un-striping logic.

## Interface
Parameters:
- COMMA, 8'hBC, idle/alignment byte; never appears as a data byte.
- LOCK_COUNT, 4, consecutive aligned commas required to go active (range 2..15).

Ports:
- clk  input  1  bit clock (32f domain); all state updates on rising edge.
- reset  input  1  asynchronous, active-low; low clears all state immediately.
- data_in  input  1  serial lane bit, MSB of each byte first.
- data_out  output  32  last assembled word; first received byte in [31:24].
- valid_out  output  1  one-cycle pulse when data_out is updated.
- active  output  1  lane aligned and locked; sticky until reset.
- word_err  output  1  one-cycle pulse when a comma truncates a partial word.

## Operation
- Shift register: sr[7:0] <= {sr[6:0], data_in} every cycle. Candidate byte nb = {sr[6:0], data_in}.
- bit_cnt (3 bits) tracks position within the byte. A byte boundary is a cycle with bit_cnt==7 in COUNT/ACTIVE; nb is the completed byte.
- SEARCH (reset state):
  - nb is compared against COMMA every cycle, i.e. at every bit offset.
  - On match: bit_cnt<=0, comma_cnt<=1, go to COUNT.
- COUNT: bit_cnt increments and wraps 7->0. At each boundary:
  - nb==COMMA: comma_cnt++. If the new value equals LOCK_COUNT, go to ACTIVE and set active<=1.
  - nb!=COMMA: comma_cnt<=0, go to SEARCH.
- ACTIVE: alignment is frozen; there is no loss-of-lock exit, only reset leaves this state. At each boundary:
  - nb==COMMA, byte_idx!=0: partial word discarded, byte_idx<=0, word_err pulses.
  - nb==COMMA, byte_idx==0: idle, no action.
  - nb!=COMMA, byte_idx<3: acc <= {acc[23:0], nb}, byte_idx++.
  - nb!=COMMA, byte_idx==3: data_out <= {acc[23:0], nb}, valid_out pulses, byte_idx<=0.
- data_out holds its value between words. Commas between words are allowed in any count.
- A data byte equal to COMMA is illegal upstream; the receiver always treats it as idle.

## Timing
- Reset values:
  - data_out=32'h0, valid_out=0, active=0, word_err=0.
  - state=SEARCH, sr=0, bit_cnt=0, comma_cnt=0, byte_idx=0, acc=0.
- All outputs are registered. "Edge N" below means the clk edge that samples the last bit of the named byte.
- Lock: active rises at the edge sampling the last bit of the LOCK_COUNT-th consecutive comma. With defaults and an aligned stream, this is 32 bits after the first comma bit.
- Word latency: valid_out is high for exactly the one cycle following the edge that samples bit 0 of the 4th data byte.
  - Back-to-back words give valid_out pulses every 32 cycles.
- word_err has the same one-cycle pulse timing, on the boundary of the offending comma.
- A non-comma byte in COUNT drops to SEARCH. The search resumes on the next bit, without waiting for a byte boundary.
- reset low mid-operation: outputs clear asynchronously, independent of clk. After reset, the lane must re-acquire from SEARCH.

## Test plan
- Reset: drive random bits with reset=0 for 20 cycles -> data_out=0, valid_out=0, active=0, word_err=0 throughout.
- Aligned lock and word:
  - Stimulus: 4x 8'hBC, then bytes FF FF FF FF.
  - Response: active=1 right after bit 32; one valid_out pulse after bit 64 with data_out=32'hFFFFFFFF.
- Offset acquisition:
  - Stimulus: 3 junk bits 101, then 4x BC, then EE EE EE EE, DD DD DD DD.
  - Response: active=1; two valid pulses 32 cycles apart, data_out=EEEEEEEE then DDDDDDDD.
- Failed lock:
  - Stimulus: BC BC BC 00, then 4x BC, then 00 00 00 03.
  - Response: active stays 0 through byte 4; active=1 after the second comma run; data_out=32'h00000003.
- Truncated word:
  - Stimulus: in ACTIVE, send AA 99 BC, then AA AA AA AA.
  - Response: word_err pulses once at the BC boundary with no valid_out; then valid_out with data_out=AAAAAAAA.
- Reset mid-word:
  - Stimulus: in ACTIVE after 2 data bytes, pulse reset low for 3 cycles, then resend 4x BC, then CC CC CC CC.
  - Response: active drops immediately and no stale word is emitted; after relock, data_out=CCCCCCCC.
